// File: rtl/bram_cfg_fifo_pkg.sv
// Shared types and helpers for the configurable BRAM/FIFO tile.
// Width-mode encoding, lane mask generation and lane width calculation.
package bram_cfg_pkg;

    localparam int MAX_LANES = 32;

    typedef enum logic [1:0] {
        WMODE_FULL = 2'd0,
        WMODE_HALF = 2'd1,
        WMODE_LANE = 2'd2
    } wmode_e;

    // Configuration value 3 is an alias for full width.
    function automatic wmode_e decode_mode(input logic [1:0] cfg);
        case (cfg)
            2'd1:    return WMODE_HALF;
            2'd2:    return WMODE_LANE;
            default: return WMODE_FULL;
        endcase
    endfunction

    function automatic int lane_width(input int data_width, input int lanes);
        return data_width / lanes;
    endfunction

    function automatic logic [MAX_LANES-1:0] lane_mask(input wmode_e mode,
                                                       input logic [1:0] sel,
                                                       input int lanes);
        logic [MAX_LANES-1:0] m;
        m = '0;
        for (int i = 0; i < MAX_LANES; i++) begin
            if (i < lanes) begin
                case (mode)
                    WMODE_HALF: m[i] = sel[0] ? (i >= lanes / 2) : (i < lanes / 2);
                    WMODE_LANE: m[i] = (i == (int'(sel) % lanes));
                    default:    m[i] = 1'b1;
                endcase
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/bram_cfg_fifo_if.sv
// Data-path bundle of the BRAM tile: write/read requests and FIFO status.
interface bram_cfg_fifo_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  wr_en;
    logic [1:0]            wr_lane;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic                  rd_en;
    logic [1:0]            rd_lane;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_valid;
    logic                  full;
    logic                  empty;
    logic [ADDR_WIDTH:0]   fill_level;
    logic                  overflow;
    logic                  underflow;

    modport master (
        output wr_addr, wr_data, wr_en, wr_lane, rd_addr, rd_en, rd_lane,
        input  rd_data, rd_valid, full, empty, fill_level, overflow, underflow
    );

    modport slave (
        input  wr_addr, wr_data, wr_en, wr_lane, rd_addr, rd_en, rd_lane,
        output rd_data, rd_valid, full, empty, fill_level, overflow, underflow
    );
endinterface

// File: rtl/bram_cfg_fifo_mem.sv
// Dual-port synchronous RAM array with per-byte write enables and a
// registered, read-first read port whose output register clears on reset.
module bram_cfg_mem #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    we,
    input  logic [ADDR_WIDTH-1:0]   waddr,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] be,
    input  logic                    re,
    input  logic [ADDR_WIDTH-1:0]   raddr,
    output logic [DATA_WIDTH-1:0]   rdata
);
    localparam int BYTES = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < BYTES; b++) begin
                if (be[b]) mem[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n)  rdata <= '0;
        else if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/bram_cfg_fifo.sv
// Configurable BRAM tile: RAM mode with full/half/lane access or FIFO mode.
// Build option BRAM_RDW_BYPASS_EN makes same-address RAM accesses write-first.
module bram_cfg_fifo
    import bram_cfg_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32,
    parameter int LANES      = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic C0,
    input  logic C1,
    input  logic C2,
    input  logic C3,
    input  logic C4,
    input  logic C5,
    input  logic C6,
    bram_cfg_fifo_if.slave bus
);
    localparam int LW    = lane_width(DATA_WIDTH, LANES);
    localparam int HW    = DATA_WIDTH / 2;
    localparam int BYTES = DATA_WIDTH / 8;
    localparam int BPL   = LW / 8;
    localparam int LSW   = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [ADDR_WIDTH:0] PTR_ONE = 1;

    logic   fifo_mode;
    wmode_e wmode_eff, rmode_eff;

    assign fifo_mode = C6;
    assign wmode_eff = fifo_mode ? WMODE_FULL : decode_mode({C1, C0});
    assign rmode_eff = fifo_mode ? WMODE_FULL : decode_mode({C3, C2});

    logic [ADDR_WIDTH:0] wr_ptr_reg, rd_ptr_reg;
    logic                overflow_reg, underflow_reg;
    logic                full, empty, pop_ok, push_ok;

    assign empty   = (wr_ptr_reg == rd_ptr_reg);
    assign full    = (wr_ptr_reg[ADDR_WIDTH-1:0] == rd_ptr_reg[ADDR_WIDTH-1:0]) &&
                     (wr_ptr_reg[ADDR_WIDTH] != rd_ptr_reg[ADDR_WIDTH]);
    assign pop_ok  = fifo_mode & bus.rd_en & ~empty;
    assign push_ok = fifo_mode & bus.wr_en & (~full | pop_ok);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else begin
            if (push_ok) wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
            if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
            if (fifo_mode && bus.wr_en && !push_ok) overflow_reg  <= 1'b1;
            if (fifo_mode && bus.rd_en && empty)    underflow_reg <= 1'b1;
        end
    end

    assign bus.full       = full;
    assign bus.empty      = empty;
    assign bus.fill_level = wr_ptr_reg - rd_ptr_reg;
    assign bus.overflow   = overflow_reg;
    assign bus.underflow  = underflow_reg;

    // Write steering: replicate the LSB-aligned chunk everywhere, let the mask pick.
    logic                  mem_we, mem_re;
    logic [ADDR_WIDTH-1:0] mem_waddr, mem_raddr;
    logic [LANES-1:0]      wr_lmask;
    logic [BYTES-1:0]      byte_mask;
    logic [DATA_WIDTH-1:0] lane_rep, half_rep, wdata, mem_q;

    assign mem_we    = rst_n & (fifo_mode ? push_ok : (bus.wr_en | C4));
    assign mem_re    = rst_n & (fifo_mode ? pop_ok : bus.rd_en);
    assign mem_waddr = fifo_mode ? wr_ptr_reg[ADDR_WIDTH-1:0] : bus.wr_addr;
    assign mem_raddr = fifo_mode ? rd_ptr_reg[ADDR_WIDTH-1:0] : bus.rd_addr;
    assign wr_lmask  = LANES'(lane_mask(wmode_eff, bus.wr_lane, LANES));
    assign half_rep  = {2{bus.wr_data[HW-1:0]}};

    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane_rep
            assign lane_rep[gi*LW +: LW] = bus.wr_data[LW-1:0];
        end
        for (genvar gi = 0; gi < BYTES; gi++) begin : g_byte_mask
            assign byte_mask[gi] = wr_lmask[gi / BPL];
        end
    endgenerate

    always_comb begin
        wdata = bus.wr_data;
        case (wmode_eff)
            WMODE_HALF: wdata = half_rep;
            WMODE_LANE: wdata = lane_rep;
            default:    ;
        endcase
    end

    bram_cfg_mem #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .DATA_WIDTH(DATA_WIDTH)
    ) u_mem (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (mem_we),
        .waddr (mem_waddr),
        .wdata (wdata),
        .be    (byte_mask),
        .re    (mem_re),
        .raddr (mem_raddr),
        .rdata (mem_q)
    );

    logic [DATA_WIDTH-1:0] merged;

`ifdef BRAM_RDW_BYPASS_EN
    // Captured only on reads so a bypassed word stays stable while rd_data holds.
    logic                  byp_hit_reg;
    logic [DATA_WIDTH-1:0] byp_data_reg;
    logic [BYTES-1:0]      byp_mask_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            byp_hit_reg  <= 1'b0;
            byp_data_reg <= '0;
            byp_mask_reg <= '0;
        end else if (mem_re) begin
            byp_hit_reg  <= mem_we & ~fifo_mode & (mem_waddr == mem_raddr);
            byp_data_reg <= wdata;
            byp_mask_reg <= byte_mask;
        end
    end

    generate
        for (genvar gi = 0; gi < BYTES; gi++) begin : g_bypass
            assign merged[gi*8 +: 8] = (byp_hit_reg && byp_mask_reg[gi]) ?
                                       byp_data_reg[gi*8 +: 8] : mem_q[gi*8 +: 8];
        end
    endgenerate
`else
    assign merged = mem_q;
`endif

    logic              valid1_reg, valid2_reg;
    logic [1:0]        rd_lane_reg;
    logic [DATA_WIDTH-1:0] out_reg, steered;
    logic [LW-1:0]     lane_words [LANES];
    logic [HW-1:0]     half_word;
    logic [LSW-1:0]    lane_idx;

    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane_words
            assign lane_words[gi] = merged[gi*LW +: LW];
        end
    endgenerate

    assign lane_idx  = LSW'(rd_lane_reg);
    assign half_word = rd_lane_reg[0] ? merged[DATA_WIDTH-1:HW] : merged[HW-1:0];

    always_comb begin
        steered = merged;
        case (rmode_eff)
            WMODE_HALF: steered = DATA_WIDTH'(half_word);
            WMODE_LANE: steered = DATA_WIDTH'(lane_words[lane_idx]);
            default:    ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid1_reg  <= 1'b0;
            valid2_reg  <= 1'b0;
            rd_lane_reg <= '0;
            out_reg     <= '0;
        end else begin
            valid1_reg <= mem_re;
            valid2_reg <= valid1_reg;
            if (mem_re)     rd_lane_reg <= bus.rd_lane;
            if (valid1_reg) out_reg     <= steered;
        end
    end

    assign bus.rd_data  = C5 ? out_reg : steered;
    assign bus.rd_valid = C5 ? valid2_reg : valid1_reg;

endmodule

// File: tb/tb_bram_cfg_fifo.sv
// Randomized bench for bram_cfg_fifo against a queue/array reference model.
module tb_bram_cfg_fifo;
    localparam int AW    = 8;
    localparam int DW    = 32;
    localparam int LANES = 4;
    localparam int DEPTH = 2**AW;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic c0 = 0, c1 = 0, c2 = 0, c3 = 0, c4 = 0, c5 = 0, c6 = 0;

    always #5 clk = ~clk;

    bram_cfg_fifo_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    bram_cfg_fifo #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LANES(LANES)) dut (
        .clk(clk), .rst_n(rst_n),
        .C0(c0), .C1(c1), .C2(c2), .C3(c3), .C4(c4), .C5(c5), .C6(c6),
        .bus(bus)
    );

    typedef struct { bit v; logic [DW-1:0] d; } rd_t;

    int checks = 0;
    int errors = 0;
    logic [DW-1:0] mem_m [DEPTH];
    rd_t           pipe [$];
    logic [DW-1:0] fq [$];
    logic [DW-1:0] last_d;
    bit            of_m, uf_m;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int eff_mode(input logic [1:0] v);
        return (v == 2'd3) ? 0 : int'(v);
    endfunction

    function automatic logic [DW-1:0] write_merge(input logic [DW-1:0] old, input logic [DW-1:0] d,
                                                  input int mode, input logic [1:0] lane);
        logic [DW-1:0] w;
        w = old;
        case (mode)
            1:       w[int'(lane[0])*16 +: 16] = d[15:0];
            2:       w[int'(lane)*8 +: 8]      = d[7:0];
            default: w = d;
        endcase
        return w;
    endfunction

    function automatic logic [DW-1:0] read_pick(input logic [DW-1:0] word, input int mode,
                                                input logic [1:0] lane);
        case (mode)
            1:       return DW'(word[int'(lane[0])*16 +: 16]);
            2:       return DW'(word[int'(lane)*8 +: 8]);
            default: return word;
        endcase
    endfunction

    task automatic check_status();
        check_eq("fill_level", bus.fill_level, fq.size());
        check_eq("full", bus.full, fq.size() == DEPTH);
        check_eq("empty", bus.empty, fq.size() == 0);
        check_eq("overflow", bus.overflow, of_m);
        check_eq("underflow", bus.underflow, uf_m);
    endtask

    task automatic do_reset(input bit fifo, input logic [1:0] wcfg, input logic [1:0] rcfg,
                            input bit force_we, input bit xreg);
        rst_n = 1'b0;
        {c1, c0} = wcfg;
        {c3, c2} = rcfg;
        c4 = force_we;
        c5 = xreg;
        c6 = fifo;
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
        @(posedge clk); #1;
        pipe.delete();
        if (xreg) pipe.push_back('{v: 1'b0, d: '0});
        last_d = '0;
        fq.delete();
        of_m = 1'b0;
        uf_m = 1'b0;
        check_eq("reset_rd_valid", bus.rd_valid, 1'b0);
        check_eq("reset_rd_data", bus.rd_data, '0);
        check_status();
        rst_n = 1'b1;
    endtask

    // One clock: advance the model with the current inputs, then compare.
    task automatic step();
        rd_t e;
        logic [DW-1:0] old_w, new_w, word;
        bit pop_ok, push_ok, we;
        e.v = 1'b0;
        e.d = '0;
        new_w = '0;
        if (c6) begin
            pop_ok  = bus.rd_en && (fq.size() > 0);
            push_ok = bus.wr_en && ((fq.size() < DEPTH) || pop_ok);
            if (bus.rd_en && fq.size() == 0) uf_m = 1'b1;
            if (bus.wr_en && !push_ok)       of_m = 1'b1;
            if (pop_ok) begin
                e.v = 1'b1;
                e.d = fq.pop_front();
            end
            if (push_ok) fq.push_back(bus.wr_data);
        end else begin
            we    = bus.wr_en || c4;
            old_w = mem_m[bus.rd_addr];
            if (we) new_w = write_merge(mem_m[bus.wr_addr], bus.wr_data, eff_mode({c1, c0}), bus.wr_lane);
            if (bus.rd_en) begin
                word = old_w;
`ifdef BRAM_RDW_BYPASS_EN
                if (we && bus.wr_addr == bus.rd_addr) word = new_w;
`endif
                e.v = 1'b1;
                e.d = read_pick(word, eff_mode({c3, c2}), bus.rd_lane);
            end
            if (we) mem_m[bus.wr_addr] = new_w;
        end
        pipe.push_back(e);
        @(posedge clk); #1;
        e = pipe.pop_front();
        if (e.v) last_d = e.d;
        check_eq("rd_valid", bus.rd_valid, e.v);
        check_eq("rd_data", bus.rd_data, last_d);
        check_status();
    endtask

    task automatic rand_ram(input int n);
        for (int i = 0; i < n; i++) begin
            bus.wr_en   = 1'($urandom);
            bus.rd_en   = 1'($urandom);
            bus.wr_addr = 8'h20 + AW'($urandom_range(15));
            bus.rd_addr = 8'h20 + AW'($urandom_range(15));
            bus.wr_data = $urandom;
            bus.wr_lane = 2'($urandom);
            bus.rd_lane = 2'($urandom);
            step();
        end
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
    endtask

    task automatic rand_fifo(input int n, input int pw, input int pr);
        for (int i = 0; i < n; i++) begin
            bus.wr_en   = ($urandom_range(99) < pw);
            bus.rd_en   = ($urandom_range(99) < pr);
            bus.wr_addr = AW'($urandom);
            bus.rd_addr = AW'($urandom);
            bus.wr_lane = 2'($urandom);
            bus.rd_lane = 2'($urandom);
            bus.wr_data = $urandom;
            step();
        end
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
    endtask

    task automatic fifo_fill(input int n, input int base);
        bus.rd_en = 1'b0;
        bus.wr_en = 1'b1;
        for (int i = 0; i < n; i++) begin
            bus.wr_data = DW'(base + i);
            step();
        end
        bus.wr_en = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: time %0t reached, expected $finish earlier", $time);
        $fatal(1);
    end

    initial begin
        bus.wr_addr = '0; bus.wr_data = '0; bus.wr_en = 1'b0; bus.wr_lane = '0;
        bus.rd_addr = '0; bus.rd_en = 1'b0; bus.rd_lane = '0;
        do_reset(1'b0, 2'd0, 2'd0, 1'b0, 1'b0);

        // Initialise every word, then read all of them back.
        bus.wr_en = 1'b1;
        for (int a = 0; a < DEPTH; a++) begin
            bus.wr_addr = AW'(a);
            bus.wr_data = $urandom;
            step();
        end
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b1;
        for (int a = 0; a < DEPTH; a++) begin
            bus.rd_addr = AW'(a);
            step();
        end
        bus.rd_en = 1'b0;

        bus.wr_en = 1'b1; bus.wr_addr = 8'h10; bus.wr_data = 32'hDEADBEEF; step();
        bus.wr_addr = 8'h05; bus.wr_data = 32'h11223344; step();
        bus.wr_addr = 8'h30; bus.wr_data = 32'h0; step();
        bus.wr_en = 1'b0; bus.rd_en = 1'b1; bus.rd_addr = 8'h10; step();
        check_eq("ram_n1_valid", bus.rd_valid, 1'b1);
        check_eq("ram_n1_data", bus.rd_data, 32'hDEADBEEF);
        bus.wr_en = 1'b1; bus.wr_addr = 8'h30; bus.wr_data = 32'h5A5A5A5A; bus.rd_addr = 8'h30; step();
`ifdef BRAM_RDW_BYPASS_EN
        check_eq("rdw_same_addr", bus.rd_data, 32'h5A5A5A5A);
`else
        check_eq("rdw_same_addr", bus.rd_data, 32'h0);
`endif
        bus.wr_en = 1'b0; bus.rd_en = 1'b0;
        rand_ram(300);

        do_reset(1'b0, 2'd0, 2'd0, 1'b0, 1'b1);
        bus.rd_en = 1'b1; bus.rd_addr = 8'h10; step();
        check_eq("ram_n2_not_yet", bus.rd_valid, 1'b0);
        bus.rd_en = 1'b0; step();
        check_eq("ram_n2_valid", bus.rd_valid, 1'b1);
        check_eq("ram_n2_data", bus.rd_data, 32'hDEADBEEF);
        rand_ram(200);

        do_reset(1'b0, 2'd2, 2'd0, 1'b0, 1'b0);
        bus.wr_en = 1'b1; bus.wr_addr = 8'h05; bus.wr_data = 32'h000000AB; bus.wr_lane = 2'd2; step();
        bus.wr_en = 1'b0; bus.rd_en = 1'b1; bus.rd_addr = 8'h05; step();
        check_eq("lane_write_full_read", bus.rd_data, 32'h11AB3344);
        bus.rd_en = 1'b0;
        do_reset(1'b0, 2'd0, 2'd2, 1'b0, 1'b0);
        bus.rd_en = 1'b1; bus.rd_addr = 8'h05; bus.rd_lane = 2'd2; step();
        check_eq("lane_read", bus.rd_data, 32'h000000AB);
        bus.rd_en = 1'b0;

        for (int k = 0; k < 10; k++) begin
            do_reset(1'b0, 2'($urandom), 2'($urandom), ($urandom_range(3) == 0), 1'($urandom));
            rand_ram(150);
        end

        // FIFO: fill, overflow, ordered drain.
        do_reset(1'b1, 2'($urandom), 2'($urandom), 1'($urandom), 1'b0);
        fifo_fill(DEPTH, 0);
        check_eq("fifo_full_flag", bus.full, 1'b1);
        check_eq("fifo_full_level", bus.fill_level, 9'd256);
        bus.wr_en = 1'b1; bus.wr_data = 32'd999; step();
        bus.wr_en = 1'b0;
        check_eq("fifo_overflow", bus.overflow, 1'b1);
        bus.rd_en = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            step();
            check_eq("pop_order", bus.rd_data, DW'(i));
        end
        bus.rd_en = 1'b0;
        check_eq("empty_after_drain", bus.empty, 1'b1);

        do_reset(1'b1, 2'd0, 2'd0, 1'b0, 1'b0);
        fifo_fill(DEPTH, 0);
        bus.wr_en = 1'b1; bus.rd_en = 1'b1; bus.wr_data = 32'h1234; step();
        check_eq("pp_full_level", bus.fill_level, 9'd256);
        check_eq("pp_full_overflow", bus.overflow, 1'b0);
        check_eq("pp_full_pop_data", bus.rd_data, 32'd0);
        bus.wr_en = 1'b0; bus.rd_en = 1'b0;

        do_reset(1'b1, 2'd0, 2'd0, 1'b0, 1'b0);
        bus.wr_en = 1'b1; bus.rd_en = 1'b1; bus.wr_data = 32'd77; step();
        check_eq("pp_empty_level", bus.fill_level, 9'd1);
        check_eq("pp_empty_underflow", bus.underflow, 1'b1);
        check_eq("pp_empty_no_valid", bus.rd_valid, 1'b0);
        bus.wr_en = 1'b0; bus.rd_en = 1'b0;

        do_reset(1'b1, 2'($urandom), 2'($urandom), 1'($urandom), 1'($urandom));
        rand_fifo(800, 70, 30);
        rand_fifo(800, 30, 70);
        rand_fifo(300, 50, 50);

        // Reset with entries queued and a pop still in the output pipeline.
        do_reset(1'b1, 2'd0, 2'd0, 1'b0, 1'b1);
        fifo_fill(10, 1);
        bus.rd_en = 1'b1; step();
        bus.rd_en = 1'b0; step();
        check_eq("pre_reset_data", bus.rd_data, 32'd1);
        bus.rd_en = 1'b1; step();
        do_reset(1'b1, 2'd0, 2'd0, 1'b0, 1'b1);
        idle_cycles: for (int i = 0; i < 3; i++) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
